// File: rtl/iua_uart_tx_arb_if.sv
// Byte-stream bundle shared by the two packet requesters, the arbiter and the UART TX serializer.
interface iua_uart_tx_arb_if;
  logic [7:0] s0_data;
  logic       s0_last;
  logic       s0_valid;
  logic       s0_ready;
  logic [7:0] s1_data;
  logic       s1_last;
  logic       s1_valid;
  logic       s1_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  // Arbiter view: consumes both requester streams, produces the UART byte stream.
  modport slave (
    input  s0_data, s0_last, s0_valid,
    output s0_ready,
    input  s1_data, s1_last, s1_valid,
    output s1_ready,
    output m_data, m_valid,
    input  m_ready
  );

  // Requester/serializer view.
  modport master (
    output s0_data, s0_last, s0_valid,
    input  s0_ready,
    output s1_data, s1_last, s1_valid,
    input  s1_ready,
    input  m_data, m_valid,
    output m_ready
  );
endinterface

// File: rtl/iua_uart_tx_arb.sv
// Packet-level round-robin arbiter between capture data (s0) and command responses (s1)
// onto the single UART TX byte stream, with optional channel header and stall watchdog.
module iua_uart_tx_arb #(
  parameter bit          HDR_EN     = 1'b1,
  parameter int unsigned TIMEOUT    = 4096,
  parameter logic [7:0]  ABORT_BYTE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  iua_uart_tx_arb_if.slave  bus,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err_timeout
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  localparam bit          WD_ON   = (TIMEOUT != 0);
  localparam logic [15:0] WD_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic        owner;
  logic        rr;
  logic [15:0] wdog;
  logic [7:0]  m_data_q;
  logic        m_valid_q;

  logic        out_free;
  logic        in_data;
  logic        own_valid;
  logic        own_last;
  logic [7:0]  own_data;
  logic        own_xfer;
  logic        pick;

  assign out_free = ~m_valid_q | bus.m_ready;
  assign in_data  = (state == S_DATA);

  always_comb begin
    own_valid = bus.s0_valid;
    own_last  = bus.s0_last;
    own_data  = bus.s0_data;
    if (owner) begin
      own_valid = bus.s1_valid;
      own_last  = bus.s1_last;
      own_data  = bus.s1_data;
    end
  end

  assign own_xfer = in_data & own_valid & out_free;

  // A lone requester wins outright; in a contest the one that did not own last time wins.
  assign pick = (bus.s0_valid & bus.s1_valid) ? ~rr : bus.s1_valid;

  assign bus.s0_ready = in_data & ~owner & out_free;
  assign bus.s1_ready = in_data &  owner & out_free;
  assign bus.m_data   = m_data_q;
  assign bus.m_valid  = m_valid_q;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      rr          <= 1'b1;
      wdog        <= '0;
      grant       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.s0_valid || bus.s1_valid) begin
            owner <= pick;
            rr    <= pick;
            grant <= pick ? 2'b10 : 2'b01;
            wdog  <= '0;
            state <= HDR_EN ? S_HDR : S_DATA;
          end
        end
        S_HDR: begin
          if (out_free) begin
            m_data_q  <= {7'h40, owner};
            m_valid_q <= 1'b1;
            wdog      <= '0;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          // A transfer always beats the watchdog, so a last byte on the expiry cycle is kept.
          if (own_xfer) begin
            m_data_q  <= own_data;
            m_valid_q <= 1'b1;
            wdog      <= '0;
            if (own_last) state <= S_DRAIN;
          end else if (!own_valid) begin
            if (WD_ON && (wdog == WD_LAST)) state <= S_ABORT;
            else                            wdog  <= wdog + 16'd1;
          end
        end
        S_DRAIN: begin
          if (out_free) begin
            state <= S_IDLE;
            grant <= '0;
          end
        end
        S_ABORT: begin
          if (out_free) begin
            err_timeout <= 1'b1;
            if (HDR_EN) begin
              m_data_q  <= ABORT_BYTE;
              m_valid_q <= 1'b1;
              state     <= S_DRAIN;
            end else begin
              state <= S_IDLE;
              grant <= '0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iua_uart_tx_arb.sv
// Self-checking bench: randomized packet traffic compared against a packet-order model of the arbiter.
module tb_iua_uart_tx_arb;
  localparam int unsigned TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant;
  logic       busy;
  logic       err_timeout;

  iua_uart_tx_arb_if bus ();

  iua_uart_tx_arb #(
    .HDR_EN     (1'b1),
    .TIMEOUT    (TMO),
    .ABORT_BYTE (8'hFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant       (grant),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gap;   // cycles the source holds valid low after this byte transfers
    logic       last;
    logic [7:0] data;
  } ent_t;

  int         vectors = 0;
  int         miscompares = 0;
  ent_t       src0[$];
  ent_t       src1[$];
  logic [7:0] obs[$];
  logic [7:0] exp_q[$];
  int         err_pulses;
  int         err_delay;
  int         cyc_last_acc;
  int         cyc_busy_fall;

  function automatic ent_t mk(input logic [7:0] gap, input logic last, input logic [7:0] data);
    ent_t e;
    e.gap = gap; e.last = last; e.data = data;
    return e;
  endfunction

  function automatic void add_pkt(input bit s, input int len, input int maxgap);
    for (int i = 0; i < len; i++) begin
      ent_t e;
      e.data = 8'($urandom);
      e.last = (i == len - 1);
      e.gap  = e.last ? 8'd0 : 8'($urandom_range(maxgap));
      if (s) src1.push_back(e);
      else   src0.push_back(e);
    end
  endfunction

  // Whole packets, header first; both sources always have a packet ready when the link is idle.
  function automatic void build_expected();
    int   i0 = 0;
    int   i1 = 0;
    logic last_own = 1'b1;
    logic own;
    exp_q.delete();
    while (i0 < src0.size() || i1 < src1.size()) begin
      if (i0 < src0.size() && i1 < src1.size()) own = ~last_own;
      else                                      own = (i1 < src1.size());
      last_own = own;
      exp_q.push_back(own ? 8'h81 : 8'h80);
      if (!own) begin
        do begin exp_q.push_back(src0[i0].data); i0++; end while (!src0[i0-1].last);
      end else begin
        do begin exp_q.push_back(src1[i1].data); i1++; end while (!src1[i1-1].last);
      end
    end
  endfunction

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.s0_valid = 1'b0; bus.s0_data = '0; bus.s0_last = 1'b0;
    bus.s1_valid = 1'b0; bus.s1_data = '0; bus.s1_last = 1'b0;
    bus.m_ready  = 1'b0;
    src0.delete(); src1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_traffic(input int mready_pct, input int budget);
    int         g0 = 0, g1 = 0, cyc = 0, last_x0 = 0;
    bit         x0 = 0, x1 = 0, done = 0, hold = 0;
    logic [7:0] held = '0;
    obs.delete();
    err_pulses = 0; err_delay = -1; cyc_last_acc = -1; cyc_busy_fall = -1;
    while (!done) begin
      @(negedge clk);
      if (x0) begin g0 = int'(src0[0].gap); src0.delete(0); end
      if (x1) begin g1 = int'(src1[0].gap); src1.delete(0); end
      if (g0 > 0 || src0.size() == 0) begin
        if (g0 > 0) g0--;
        bus.s0_valid = 1'b0; bus.s0_data = 8'($urandom); bus.s0_last = 1'($urandom);
      end else begin
        bus.s0_valid = 1'b1; bus.s0_data = src0[0].data; bus.s0_last = src0[0].last;
      end
      if (g1 > 0 || src1.size() == 0) begin
        if (g1 > 0) g1--;
        bus.s1_valid = 1'b0; bus.s1_data = 8'($urandom); bus.s1_last = 1'($urandom);
      end else begin
        bus.s1_valid = 1'b1; bus.s1_data = src1[0].data; bus.s1_last = src1[0].last;
      end
      bus.m_ready = ($urandom_range(99) < mready_pct);
      #1;
      cyc++;
      if (hold) begin
        vectors++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== held) begin
          miscompares++;
          $display("FAIL stall_hold: cyc %0d m_valid=%b m_data=%h, required m_valid=1 m_data=%h",
                   cyc, bus.m_valid, bus.m_data, held);
        end
      end
      vectors++;
      if ((bus.s0_ready && grant !== 2'b01) || (bus.s1_ready && grant !== 2'b10) ||
          (busy ? !(grant === 2'b01 || grant === 2'b10) : (grant !== 2'b00)) ||
          ((bus.s0_ready || bus.s1_ready) && bus.m_valid && !bus.m_ready)) begin
        miscompares++;
        $display("FAIL ownership: cyc %0d grant=%b busy=%b s0_ready=%b s1_ready=%b m_valid=%b m_ready=%b",
                 cyc, grant, busy, bus.s0_ready, bus.s1_ready, bus.m_valid, bus.m_ready);
      end
      if (err_timeout) begin
        err_pulses++;
        if (err_delay < 0) err_delay = cyc - last_x0;
      end
      x0 = bus.s0_valid & bus.s0_ready;
      x1 = bus.s1_valid & bus.s1_ready;
      if (x0) last_x0 = cyc;
      if (bus.m_valid && bus.m_ready) begin
        obs.push_back(bus.m_data);
        cyc_last_acc  = cyc;
        cyc_busy_fall = -1;
      end
      if (!busy && cyc_busy_fall < 0 && cyc_last_acc >= 0) cyc_busy_fall = cyc;
      hold = bus.m_valid & ~bus.m_ready;
      held = bus.m_data;
      done = (src0.size() == 0) && (src1.size() == 0) && !busy && !bus.m_valid;
      if (!done && cyc >= budget) begin
        vectors++; miscompares++;
        $display("FAIL traffic_budget: %0d cycles without draining, required completion", cyc);
        done = 1;
      end
    end
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || grant !== 2'b00 || busy !== 1'b0 ||
        err_timeout !== 1'b0 || bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: m_valid=%b m_data=%h grant=%b busy=%b err=%b rdy=%b%b, required all zero",
               bus.m_valid, bus.m_data, grant, busy, err_timeout, bus.s0_ready, bus.s1_ready);
    end
  endtask

  task automatic test_single_packet();
    do_reset();
    src0.push_back(mk(8'd0, 1'b0, 8'h11));
    src0.push_back(mk(8'd0, 1'b0, 8'h22));
    src0.push_back(mk(8'd0, 1'b1, 8'h33));
    exp_q = '{8'h80, 8'h11, 8'h22, 8'h33};
    run_traffic(100, 200);
    vectors++;
    if (obs.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL single_len: got %0d bytes, required %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL single_byte[%0d]: got %h, required %h", i, obs[i], exp_q[i]);
      end
    end
    vectors++;
    if (cyc_busy_fall != cyc_last_acc + 1) begin
      miscompares++;
      $display("FAIL single_busy_drop: busy fell %0d cycles after last accept, required 1",
               cyc_busy_fall - cyc_last_acc);
    end
    vectors++;
    if (err_pulses != 0) begin
      miscompares++;
      $display("FAIL single_err: got %0d pulses, required 0", err_pulses);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    add_pkt(1'b0, 2, 0); add_pkt(1'b0, 2, 0);
    add_pkt(1'b1, 2, 0); add_pkt(1'b1, 2, 0);
    build_expected();
    run_traffic(100, 400);
    vectors++;
    if (obs.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_len: got %0d bytes, required %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_byte[%0d]: got %h, required %h", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    add_pkt(1'b1, 6, 0);
    build_expected();
    run_traffic(45, 600);
    vectors++;
    if (obs.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL bp_len: got %0d bytes, required %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL bp_byte[%0d]: got %h, required %h", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int p = 0; p < int'($urandom_range(3)); p++) add_pkt(1'b0, 1 + int'($urandom_range(5)), 6);
      for (int p = 0; p < int'($urandom_range(3)); p++) add_pkt(1'b1, 1 + int'($urandom_range(5)), 6);
      build_expected();
      run_traffic(30 + int'($urandom_range(70)), 3000);
      vectors++;
      if (obs.size() != exp_q.size() || err_pulses != 0) begin
        miscompares++;
        $display("FAIL rand_len[%0d]: got %0d bytes %0d aborts, required %0d bytes 0 aborts",
                 it, obs.size(), err_pulses, exp_q.size());
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        vectors++;
        if (obs[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand_byte[%0d][%0d]: got %h, required %h", it, i, obs[i], exp_q[i]);
        end
      end
    end
  endtask

  // Owner stalls well past the limit: 16 idle cycles, abort cycle, then the registered pulse.
  task automatic test_watchdog_abort();
    do_reset();
    src0.push_back(mk(8'd0,  1'b0, 8'hA0));
    src0.push_back(mk(8'd40, 1'b0, 8'hA1));
    src0.push_back(mk(8'd0,  1'b1, 8'hA2));
    src1.push_back(mk(8'd0,  1'b0, 8'hC0));
    src1.push_back(mk(8'd0,  1'b1, 8'hC1));
    exp_q = '{8'h80, 8'hA0, 8'hA1, 8'hFF, 8'h81, 8'hC0, 8'hC1, 8'h80, 8'hA2};
    run_traffic(100, 400);
    vectors++;
    if (obs.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL wd_len: got %0d bytes, required %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL wd_byte[%0d]: got %h, required %h", i, obs[i], exp_q[i]);
      end
    end
    vectors++;
    if (err_pulses != 1 || err_delay != int'(TMO) + 2) begin
      miscompares++;
      $display("FAIL wd_pulse: got %0d pulses at delay %0d, required 1 pulse at delay %0d",
               err_pulses, err_delay, TMO + 2);
    end
  endtask

  task automatic test_watchdog_boundary();
    // Last byte arrives on the expiry cycle: kept, no abort.
    do_reset();
    src0.push_back(mk(8'(TMO - 1), 1'b0, 8'h5C));
    src0.push_back(mk(8'd0,        1'b1, 8'h5D));
    exp_q = '{8'h80, 8'h5C, 8'h5D};
    run_traffic(100, 300);
    vectors++;
    if (obs.size() != exp_q.size() || err_pulses != 0) begin
      miscompares++;
      $display("FAIL wdb_keep_len: got %0d bytes %0d aborts, required %0d bytes 0 aborts",
               obs.size(), err_pulses, exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL wdb_keep_byte[%0d]: got %h, required %h", i, obs[i], exp_q[i]);
      end
    end
    // One cycle later: aborted, and the late byte becomes a new packet.
    do_reset();
    src0.push_back(mk(8'(TMO), 1'b0, 8'h6C));
    src0.push_back(mk(8'd0,    1'b1, 8'h6D));
    exp_q = '{8'h80, 8'h6C, 8'hFF, 8'h80, 8'h6D};
    run_traffic(100, 300);
    vectors++;
    if (obs.size() != exp_q.size() || err_pulses != 1 || err_delay != int'(TMO) + 2) begin
      miscompares++;
      $display("FAIL wdb_abort: got %0d bytes %0d aborts delay %0d, required %0d bytes 1 abort delay %0d",
               obs.size(), err_pulses, err_delay, exp_q.size(), TMO + 2);
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL wdb_abort_byte[%0d]: got %h, required %h", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit seen;
    do_reset();
    seen = 1'b0;
    bus.s0_valid = 1'b1; bus.s0_data = 8'h5A; bus.s0_last = 1'b0;
    bus.m_ready  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #1;
      seen = bus.m_valid;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL midrst_setup: m_valid=%b, required 1 within 10 cycles", bus.m_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.m_valid !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || bus.s0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: m_valid=%b grant=%b busy=%b s0_ready=%b, required all zero",
               bus.m_valid, grant, busy, bus.s0_ready);
    end
    bus.s0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    add_pkt(1'b0, 1, 0);
    add_pkt(1'b1, 1, 0);
    build_expected();
    run_traffic(100, 200);
    vectors++;
    if (obs.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL midrst_len: got %0d bytes, required %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midrst_byte[%0d]: got %h, required %h", i, obs[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_watchdog_abort();
    test_watchdog_boundary();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
